// File: rtl/heepsilon_pkg.sv
// heepsilon_pkg: shared powergate constants and ack channel state type.
package heepsilon_pkg;
  localparam int PG_NUM_DOMAINS = 2;
  localparam int PG_CNT_W = 8;
  localparam int PG_ON_DELAY = 8;
  localparam int PG_OFF_DELAY = 4;
  localparam int PG_DOM_CPU = 0;
  localparam int PG_DOM_PERIPH = 1;
  typedef enum logic {PG_IDLE, PG_RAMP} pg_ack_state_e;
endpackage

// File: rtl/heepsilon_pg_ack_chan.sv
// heepsilon_pg_ack_chan: single-domain switch settle model with abort counting.
module heepsilon_pg_ack_chan
  import heepsilon_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W,
  parameter int unsigned ON_DELAY = PG_ON_DELAY,
  parameter int unsigned OFF_DELAY = PG_OFF_DELAY,
  parameter logic RST_ACK_N = 1'b0,
  parameter int ABORT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               switch_ni,
  input  logic               cfg_en_i,
  input  logic [CNT_W-1:0]   cfg_on_delay_i,
  input  logic [CNT_W-1:0]   cfg_off_delay_i,
  output logic               ack_no,
  output logic               busy_o,
  output logic [ABORT_W-1:0] abort_cnt_o
);
  pg_ack_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly;
  logic [ABORT_W-1:0] abort_q, abort_d;
  logic ack_q, ack_d, req;
  assign req = switch_ni != ack_q;
  assign dly = switch_ni ? (cfg_en_i ? cfg_off_delay_i : CNT_W'(OFF_DELAY))
                         : (cfg_en_i ? cfg_on_delay_i : CNT_W'(ON_DELAY));
  // A reverted request wins over the terminal count so ack never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = ack_q;
    abort_d = abort_q;
    if (state_q == PG_IDLE) begin
      if (req) begin
        state_d = PG_RAMP;
        cnt_d = dly;
      end
    end else if (!req) begin
      state_d = PG_IDLE;
      abort_d = abort_q + ABORT_W'(~&abort_q);
    end else if (cnt_q == '0) begin
      state_d = PG_IDLE;
      ack_d = switch_ni;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PG_IDLE;
      cnt_q <= '0;
      ack_q <= RST_ACK_N;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      abort_q <= abort_d;
    end
  end
  assign ack_no = ack_q;
  assign busy_o = state_q == PG_RAMP;
  assign abort_cnt_o = abort_q;
endmodule

// File: rtl/heepsilon_pg_ack_gen.sv
// heepsilon_pg_ack_gen: delayed powergate switch_ack_n feedback for every gated domain.
module heepsilon_pg_ack_gen
  import heepsilon_pkg::*;
#(
  parameter int NUM_DOMAINS = PG_NUM_DOMAINS,
  parameter int CNT_W = PG_CNT_W,
  parameter int unsigned ON_DELAY = PG_ON_DELAY,
  parameter int unsigned OFF_DELAY = PG_OFF_DELAY,
  parameter logic RST_ACK_N = 1'b0,
  parameter int ABORT_W = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_DOMAINS-1:0]         switch_ni,
  output logic [NUM_DOMAINS-1:0]         ack_no,
  input  logic                           cfg_en_i,
  input  logic [CNT_W-1:0]               cfg_on_delay_i,
  input  logic [CNT_W-1:0]               cfg_off_delay_i,
  output logic [NUM_DOMAINS-1:0]         busy_o,
  output logic [NUM_DOMAINS*ABORT_W-1:0] abort_cnt_o
);
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_chan
    heepsilon_pg_ack_chan #(
      .CNT_W(CNT_W),
      .ON_DELAY(ON_DELAY),
      .OFF_DELAY(OFF_DELAY),
      .RST_ACK_N(RST_ACK_N),
      .ABORT_W(ABORT_W)
    ) u_chan (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .switch_ni(switch_ni[g]),
      .cfg_en_i(cfg_en_i),
      .cfg_on_delay_i(cfg_on_delay_i),
      .cfg_off_delay_i(cfg_off_delay_i),
      .ack_no(ack_no[g]),
      .busy_o(busy_o[g]),
      .abort_cnt_o(abort_cnt_o[g*ABORT_W +: ABORT_W])
    );
  end
endmodule

// File: tb/tb_heepsilon_pg_ack_gen.sv
// tb_heepsilon_pg_ack_gen: deadline-based reference model vs default and 2-bit-abort instances.
module tb_heepsilon_pg_ack_gen;
  logic clk = 0, rst = 1, cfg_en = 0;
  logic [1:0] sw = 2'b00;
  logic [7:0] on_d = 8'd0, off_d = 8'd0;
  logic [1:0] ack, busy, ack_s, busy_s;
  logic [31:0] ab;
  logic [3:0] ab_s;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int m_ack[2], m_busy[2], m_due[2], m_ab[2];
  always #5 clk = ~clk;
  heepsilon_pg_ack_gen dut (
    .clk_i(clk), .rst_i(rst), .switch_ni(sw), .ack_no(ack), .cfg_en_i(cfg_en),
    .cfg_on_delay_i(on_d), .cfg_off_delay_i(off_d), .busy_o(busy), .abort_cnt_o(ab)
  );
  heepsilon_pg_ack_gen #(.ABORT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .switch_ni(sw), .ack_no(ack_s), .cfg_en_i(cfg_en),
    .cfg_on_delay_i(on_d), .cfg_off_delay_i(off_d), .busy_o(busy_s), .abort_cnt_o(ab_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  // Each ramp gets an absolute deadline edge; reversal before or at it is an abort.
  task automatic model_edge();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ack[d] = 0; m_busy[d] = 0; m_ab[d] = 0;
      end else if (!m_busy[d]) begin
        if (int'(sw[d]) != m_ack[d]) begin
          m_busy[d] = 1;
          m_due[d] = cyc + 1 + (cfg_en ? int'(sw[d] ? off_d : on_d) : (sw[d] ? 4 : 8));
        end
      end else if (int'(sw[d]) == m_ack[d]) begin
        m_busy[d] = 0; m_ab[d]++;
      end else if (cyc == m_due[d]) begin
        m_ack[d] = int'(sw[d]); m_busy[d] = 0;
      end
    end
  endtask
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("ack", 32'(ack[d]), 32'(m_ack[d]));
        chk("busy", 32'(busy[d]), 32'(m_busy[d]));
        chk("abort", 32'(ab[d*16 +: 16]), 32'(m_ab[d] > 65535 ? 65535 : m_ab[d]));
        chk("ack_s", 32'(ack_s[d]), 32'(m_ack[d]));
        chk("busy_s", 32'(busy_s[d]), 32'(m_busy[d]));
        chk("abort_sat", 32'(ab_s[d*2 +: 2]), 32'(m_ab[d] > 3 ? 3 : m_ab[d]));
      end
    end
  endtask
  initial begin
    tick(3);
    chk("rst_ack", 32'(ack), 32'd0);
    rst = 0;
    tick(3);
    sw[0] = 1; tick(7);
    chk("off_ack", 32'(ack), 32'b01);
    sw[0] = 0; tick(11);
    sw[1] = 1; tick(3); sw[1] = 0; tick(3);
    sw[1] = 1; tick(5); sw[1] = 0; tick(3);
    chk("term_abort", 32'(ab[31:16]), 32'd2);
    cfg_en = 1; off_d = 0;
    sw[0] = 1; tick(3);
    on_d = 8'd255; sw[0] = 0; tick(1);
    on_d = 8'd2; tick(255);
    chk("long_wait", 32'(ack[0]), 32'd1);
    tick(1);
    chk("long_ack", 32'(ack[0]), 32'd0);
    cfg_en = 0; sw = 2'b11; tick(7);
    sw = 2'b00; tick(3); rst = 1; tick(2); rst = 0; tick(2);
    for (int k = 0; k < 5; k++) begin
      sw[1] = 1; tick(2); sw[1] = 0; tick(2);
    end
    chk("sat", 32'(ab_s[3:2]), 32'd3);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) sw[0] = ~sw[0];
      if ($urandom_range(0, 5) == 0) sw[1] = ~sw[1];
      if ($urandom_range(0, 30) == 0) cfg_en = ~cfg_en;
      on_d = 8'($urandom_range(0, 12));
      off_d = 8'($urandom_range(0, 12));
      rst = $urandom_range(0, 150) == 0;
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/heepsilon_pg_ack_gen.md
Name: heepsilon_pg_ack_gen

Overview:
- Powergate acknowledge model that sits directly downstream of heepsilon_top's cpu/peripheral powergate switch outputs. It produces the delayed switch_ack_n feedback those ports expect.
- Models the power-switch settle time per domain with independent on/off delays. Aborts a ramp cleanly on request reversal, and exposes busy and abort statistics.
- Instantiated in the testharness. The synthesis wrapper ties acks instead.

Parameters:
- NUM_DOMAINS, 2, number of gated domains (index 0 = cpu, 1 = peripheral).
- CNT_W, 8, width of the delay counters and delay config inputs.
- ON_DELAY, 8, default cycles from a switch-on request (switch_n 1->0) to ack.
- OFF_DELAY, 4, default cycles from a switch-off request (switch_n 0->1) to ack.
- RST_ACK_N, 1'b0, reset value of every ack_no bit (0 = domain powered, acknowledged).
- ABORT_W, 16, width of the per-domain abort counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- switch_ni  in  NUM_DOMAINS  powergate switch request, active-low (0 = power on).
- ack_no  out  NUM_DOMAINS  switch acknowledge, active-low; follows switch_ni after a delay.
- cfg_en_i  in  1  1 = use the runtime delays below; 0 = use the parameters.
- cfg_on_delay_i  in  CNT_W  runtime on-delay.
- cfg_off_delay_i  in  CNT_W  runtime off-delay.
- busy_o  out  NUM_DOMAINS  domain is ramping (request != ack).
- abort_cnt_o  out  NUM_DOMAINS*ABORT_W  per-domain count of aborted ramps; saturating.

Behaviour:
- Everything is registered on the clk_i rising edge. rst_i=1 has priority over all other activity, including mid-ramp.
- Reset values:
  - ack_no = {NUM_DOMAINS{RST_ACK_N}}.
  - busy_o = 0.
  - abort_cnt_o = 0.
  - counters = 0.
  - FSM = IDLE.
- The channel FSM is per domain and fully independent.
- IDLE:
  - If sampled switch_ni[i] != ack_no[i], go to RAMP.
  - Load cnt = D, where D = on-delay if switch_ni[i]==0, else off-delay.
  - D is taken from the cfg_* inputs when cfg_en_i=1, otherwise from the parameters.
  - Set busy_o[i]=1 on that same edge.
- RAMP:
  - If switch_ni[i] == ack_no[i] (request reverted): go to IDLE, leave ack unchanged, clear busy, and increment abort_cnt[i] (saturating at all-ones).
  - Else, if cnt==0: ack_no[i] <= switch_ni[i], go to IDLE, clear busy.
  - Else: cnt <= cnt-1.
- Latency: a new request first sampled at edge t has ack_no updated at edge t+D+1.
  - D=0 gives 1 cycle.
  - Maximum is 2^CNT_W cycles.
- Config sampling:
  - Delay inputs are sampled only at IDLE->RAMP.
  - Changing cfg_* or cfg_en_i mid-ramp does not affect the running count.
- Simultaneous events:
  - A revert on the same cycle that cnt reaches 0 counts as an abort. The revert check has priority, so ack does not toggle.
  - Requests on different domains in the same cycle ramp in parallel.
- After an abort, if switch_ni flips again on the next cycle, a fresh ramp starts with a full delay; the old count is not resumed.
- Reset mid-ramp: the ramp is discarded; ack goes to RST_ACK_N and the abort count is not incremented.
- switch_ni is assumed synchronous to clk_i; the block adds no synchronizers.

Decomposition:
- heepsilon_pkg holds the constants:
  - PG_NUM_DOMAINS=2, PG_CNT_W=8, PG_ON_DELAY=8, PG_OFF_DELAY=4.
  - Domain index constants PG_DOM_CPU=0 and PG_DOM_PERIPH=1.
  - The enum pg_ack_state_e {PG_IDLE, PG_RAMP}.
- One sub-module, heepsilon_pg_ack_chan: a single-domain FSM, counter and abort counter. The top generate-loops it NUM_DOMAINS times and shares the cfg inputs across instances.

Test Plan:
- Reset default: assert rst_i 3 cycles with switch_ni=2'b00 -> ack_no=2'b00, busy_o=0, abort_cnt_o=0; no ramp starts after release.
- Off then on, default delays:
  - switch_ni[0] 0->1 at edge t -> busy_o[0]=1 from t, and ack_no[0]=1 at edge t+5.
  - Then switch_ni[0] 1->0 -> ack_no[0]=0 after 9 cycles.
  - Domain 1 stays untouched.
- Abort:
  - switch_ni[1] 0->1, then back to 0 after 3 cycles -> ack_no[1] never toggles, busy_o[1] drops, abort_cnt[1]=1.
  - Repeat at the exact terminal cycle (cnt==0) -> abort_cnt[1]=2 and ack still 0.
- Runtime config: cfg_en_i=1, cfg_off_delay_i=0 -> ack follows after 1 cycle. Set cfg_on_delay_i=255, then change it to 2 mid-ramp -> ack after 256 cycles.
- Parallel plus reset:
  - Both domains request off in the same cycle -> both acks update on the same edge.
  - Start a new on-ramp, then assert rst_i mid-ramp -> ack_no=RST_ACK_N, busy_o=0, abort counts cleared.
- Saturation: use ABORT_W=2 and force 5 aborts -> abort_cnt stays at 3.
